// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush/forward control with D-cache miss FSM, refill watchdog and perf counters
module hazard_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             memReadE,
  input  logic             pcSrcE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             dReqM,
  input  logic             dHitM,
  input  logic             dRefillDone,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             missTimeout,
  output logic [CNT_W-1:0] missCnt,
  output logic [CNT_W-1:0] stallCnt
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {RUN, MISS, REPLAY} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic miss_hit, load_use, hold, redirect, lu, miss_ent, in_miss;
  assign miss_hit = dReqM & ~dHitM;
  assign load_use = memReadE & |rdE & (rdE == rs1D | rdE == rs2D);
  assign in_miss  = state == MISS;
  assign miss_ent = ~in_miss & miss_hit;
  // a miss freezes the whole pipe and masks redirect/load-use until release
  assign hold     = ~rst & (~(state == RUN) | miss_hit);
  assign redirect = ~rst & ~hold & pcSrcE;
  assign lu       = ~rst & ~hold & ~pcSrcE & load_use;
  assign stallF = hold | lu;
  assign stallD = hold | lu;
  assign stallE = hold;
  assign stallM = hold;
  assign flushW = hold;
  assign flushD = redirect;
  assign flushE = redirect | lu;
  assign forwardAE = rst ? 2'b00 :
                     (regWriteM & |rdM & rdM == rs1E) ? 2'b10 :
                     (regWriteW & |rdW & rdW == rs1E) ? 2'b01 : 2'b00;
  assign forwardBE = rst ? 2'b00 :
                     (regWriteM & |rdM & rdM == rs2E) ? 2'b10 :
                     (regWriteW & |rdW & rdW == rs2E) ? 2'b01 : 2'b00;
  always_comb begin
    state_nx = state;
    state_nx = in_miss ? (dRefillDone ? REPLAY : MISS) : (miss_hit ? MISS : RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      timer       <= '0;
      missTimeout <= 1'b0;
      missCnt     <= '0;
      stallCnt    <= '0;
    end else begin
      state <= state_nx;
      timer <= (in_miss & ~dRefillDone) ? ((timer == TW'(TIMEOUT_CYC - 1)) ? timer : timer + 1'b1) : '0;
      if (in_miss & ~dRefillDone & timer == TW'(TIMEOUT_CYC - 2)) missTimeout <= 1'b1;
      if (miss_ent & ~&missCnt) missCnt <= missCnt + 1'b1;
      if (stallF & ~&stallCnt) stallCnt <= stallCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed stimulus with a queued scoreboard checked by an independent negedge monitor
module tb_hazard_stall_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic memReadE, pcSrcE, regWriteM, regWriteW, dReqM, dHitM, dRefillDone;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, missTimeout;
  logic [1:0] forwardAE, forwardBE;
  logic [3:0] missCnt, stallCnt;
  logic [19:0] act;
  int total = 0, passed = 0;
  typedef struct {string n; logic [19:0] e; logic [19:0] m;} exp_t;
  exp_t q[$];
  exp_t cur;
  localparam logic [19:0] CTRL = 20'hFE000, FWD = 20'h01E00, MT = 20'h00100,
                          MC = 20'h000F0, SC = 20'h0000F, ALL = 20'hFFFFF;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.CNT_W(4), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .memReadE(memReadE), .pcSrcE(pcSrcE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .dReqM(dReqM), .dHitM(dHitM), .dRefillDone(dRefillDone),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .flushD(flushD),
    .flushE(flushE), .flushW(flushW), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .missTimeout(missTimeout), .missCnt(missCnt), .stallCnt(stallCnt));
  assign act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardAE, forwardBE,
                missTimeout, missCnt, stallCnt};
  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur = q.pop_front();
      total++;
      if (((act ^ cur.e) & cur.m) == 20'h0) passed++;
      else $display("FAIL %s: got %h expected %h (mask %h)", cur.n, act & cur.m, cur.e & cur.m, cur.m);
    end
  end
  task automatic push(input string n, input logic [6:0] c, input logic [1:0] fa, input logic [1:0] fb,
                      input logic mt, input logic [3:0] mc, input logic [3:0] sc, input logic [19:0] m);
    q.push_back('{n, {c, fa, fb, mt, mc, sc}, m});
  endtask
  task automatic idle();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {memReadE, pcSrcE, regWriteM, regWriteW, dReqM, dHitM, dRefillDone} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    memReadE = 1; rdE = 5; rs1D = 5; pcSrcE = 1; dReqM = 1; regWriteM = 1; rdM = 7; rs1E = 7;
    push("reset_hold", 7'b0, 2'b00, 2'b00, 0, 0, 0, ALL);
    step(); idle(); rst = 0;
    step(); memReadE = 1; rdE = 5; rs1D = 5;
    push("lu_rs1", 7'b1100010, 0, 0, 0, 0, 0, CTRL);
    step(); rdE = 0;
    push("lu_rd0", 7'b0, 0, 0, 0, 0, 1, CTRL | SC);
    step(); rdE = 5; rs1D = 0; rs2D = 5;
    push("lu_rs2", 7'b1100010, 0, 0, 0, 0, 1, CTRL | SC);
    step(); memReadE = 0;
    push("no_load", 7'b0, 0, 0, 0, 0, 2, CTRL | SC);
    step(); memReadE = 1; pcSrcE = 1; rs1D = 5;
    push("redirect_lu", 7'b0000110, 0, 0, 0, 0, 2, CTRL | SC);
    step(); idle(); rs1E = 7; rdM = 7; rdW = 7; regWriteM = 1; regWriteW = 1;
    push("fwdA_mem", 7'b0, 2'b10, 2'b00, 0, 0, 0, FWD | CTRL);
    step(); regWriteM = 0;
    push("fwdA_wb", 7'b0, 2'b01, 2'b00, 0, 0, 0, FWD);
    step(); rs1E = 0;
    push("fwdA_x0", 7'b0, 2'b00, 2'b00, 0, 0, 0, FWD);
    step(); rs2E = 3; rdM = 3; rdW = 3; regWriteM = 1; regWriteW = 1;
    push("fwdB_mem", 7'b0, 2'b00, 2'b10, 0, 0, 0, FWD);
    step(); rdM = 0;
    push("fwdB_wb", 7'b0, 2'b00, 2'b01, 0, 0, 0, FWD);
    step(); idle(); rst = 1;
    push("rst_clear", 7'b0, 0, 0, 0, 0, 0, ALL);
    step(); rst = 0;
    step(); dReqM = 1; dHitM = 0; pcSrcE = 1; memReadE = 1; rdE = 5; rs1D = 5;
    push("miss_entry", 7'b1111001, 0, 0, 0, 0, 0, ALL);
    for (int i = 1; i <= 10; i++) begin
      step(); dHitM = 1; dRefillDone = (i == 10);
      push($sformatf("miss_cyc%0d", i), 7'b1111001, 0, 0, i >= 4, 1, 4'(i), ALL);
    end
    step(); dRefillDone = 0;
    push("replay", 7'b1111001, 0, 0, 1, 1, 11, ALL);
    step();
    push("release_redirect", 7'b0000110, 0, 0, 1, 1, 12, ALL);
    step(); pcSrcE = 0;
    push("release_lu", 7'b1100010, 0, 0, 1, 1, 12, ALL);
    step(); memReadE = 0; dRefillDone = 1;
    push("stray_refill", 7'b0, 0, 0, 1, 1, 13, ALL);
    step(); dRefillDone = 0;
    push("run_after_stray", 7'b0, 0, 0, 1, 1, 13, ALL);
    step(); idle(); dReqM = 1; pcSrcE = 1;
    push("miss2_entry", 7'b1111001, 0, 0, 1, 1, 13, ALL);
    step();
    push("miss2", 7'b1111001, 0, 0, 1, 2, 14, ALL);
    step(); rst = 1;
    push("rst_mid_miss", 7'b0, 0, 0, 0, 0, 0, ALL);
    step(); rst = 0; idle();
    push("after_rst", 7'b0, 0, 0, 0, 0, 0, ALL);
    step(); dReqM = 1; dHitM = 0;
    push("sat_entry", 7'b1111001, 0, 0, 0, 0, 0, ALL);
    for (int k = 1; k <= 19; k++) begin
      step(); dRefillDone = 1;
      if (k == 1 || k == 8 || k >= 14)
        push($sformatf("sat_miss%0d", k), 7'b1111001, 0, 0, 0,
             4'(k > 15 ? 15 : k), 4'(2 * k - 1 > 15 ? 15 : 2 * k - 1), CTRL | MC | SC);
      step(); dRefillDone = 0;
    end
    step(); dRefillDone = 1; dHitM = 1;
    push("sat_final_miss", 7'b1111001, 0, 0, 0, 15, 15, ALL);
    step(); dRefillDone = 0;
    push("sat_replay_hit", 7'b1111001, 0, 0, 0, 15, 15, ALL);
    step(); idle();
    push("sat_run", 7'b0, 0, 0, 0, 15, 15, ALL);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d pending, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
